masked_xor_pipe: RTL and testbench
==================================

// Module: masked_xor_pipe
// PURPOSE
//  Parametrised, pipelined, share-wise XOR unit for the threshold-implementation datapath.
//  Combines a shared state with a shared operand (round key or constant) share by share,
//  with optional mask refresh from fresh randomness, behind valid/ready flow control.
//  Sits between the round-key schedule and the masked S-box layer of the Midori64 core.
//  Successor to the flat 64-bit XOR: adds share count, pipeline depth, modes and back-pressure.
// PARAMETERS
//  WIDTH   64  bits per share
//  SHARES  3   number of shares (>=2)
//  DEPTH   1   pipeline register stages (1..4)
// PORTS
//  clk        in   1               single clock, all flops on rising edge
//  rst        in   1               synchronous, active-high reset
//  in_valid   in   1               input word valid
//  in_ready   out  1               unit accepts the input word this cycle
//  mode       in   2               00 pass, 01 xor, 10 refresh, 11 xor+refresh
//  state_in   in   WIDTH*SHARES    state shares, share i at [i*WIDTH +: WIDTH]
//  opnd_in    in   WIDTH*SHARES    operand shares, same packing
//  rand_in    in   WIDTH*(SHARES-1) fresh mask words r_0..r_{SHARES-2}
//  out_valid  out  1               output word valid
//  out_ready  in   1               downstream accepts the output
//  state_out  out  WIDTH*SHARES    result shares
//  word_cnt   out  16              accepted-word counter
// BEHAVIOUR
//  - Transfer occurs on in_valid&&in_ready (input side) and on out_valid&&out_ready (output side).
//  - Stage-0 function, per share i:
//    s_i' = s_i ^ (mode[0] ? o_i : 0) ^ (mode[1] ? m_i : 0);
//    m_i = r_i for i<SHARES-1; m_{SHARES-1} = XOR of all r_k.
//    The refresh leaves the unshared value unchanged.
//  - The result is registered in stage 0. Stages 1..DEPTH-1 are plain register copies.
//    Latency is DEPTH cycles from accept to out_valid with no stall.
//  - Each stage holds a valid bit v[k]. Stage k loads when !v[k] or stage k+1 loads.
//    The last stage loads when !v[DEPTH-1] or out_ready.
//  - in_ready = stage-0 load enable. It is combinational from out_ready through the chain.
//    There is no in_valid->in_ready path.
//  - Full pipe with out_ready=1 and in_valid=1: accept and drain in the same cycle,
//    giving 1 word/cycle sustained.
//  - Full pipe with out_ready=0: in_ready=0. Data and valids hold and state_out is stable.
//  - out_valid and state_out stay stable while out_valid && !out_ready.
//  - mode and rand_in are sampled only on the accept cycle and are ignored otherwise.
//  - word_cnt increments on each input accept and wraps 0xFFFF->0x0000.
//  - Reset: all v[k]=0, all data registers=0 (no stale shares), word_cnt=0,
//    out_valid=0, state_out=0.
//    in_ready=1 in the reset cycle's following cycle.
//  - Reset mid-operation flushes all in-flight words with no output.
//    An accept coinciding with rst is discarded.
//  - Shares are never recombined in any register or wire. No cross-share logic
//    except the m_{SHARES-1} term, which uses only randomness.
// STRUCTURE
//  - Shared package: mode encodings (MODE_PASS/XOR/REFRESH/BOTH) and share-slice helper functions.
//  - One sub-module, masked_xor_stage: a single register stage with valid bit and load/hold logic.
//    It is instantiated DEPTH times via generate. Stage 0 is fed by the combinational share function.
// TESTING (WIDTH=64, SHARES=3, DEPTH=2 unless noted; unshared = XOR of shares)
//  1. Mode 01: s=(A,B,C), o=(K0,K1,K2), out_ready=1.
//     Expect the word after 2 cycles: share i = s_i^K_i; unshared = (A^B^C)^(K0^K1^K2).
//  2. Mode 10: s=(1,2,3), r=(0xFF,0xF0).
//     Expect shares (0xFE, 0xF2, 0x3^0x0F=0x0C); unshared unchanged (0).
//  3. Back-pressure: stream 4 words with out_ready=0.
//     Expect in_ready=0 after 2 accepts, then release and expect all 4 out in order with none lost.
//  4. Throughput: in_valid=1 and out_ready=1 for 100 cycles.
//     Expect 100 accepts, 98 outputs, and word_cnt=100.
//  5. Reset mid-stream with 2 words in flight.
//     Expect out_valid=0, state_out=0 and word_cnt=0 the next cycle, and no stale word emitted afterwards.
//  6. Counter wrap: preload via 65535 accepts, then 1 more.
//     Expect word_cnt=0. Repeat test 1 with DEPTH=1 and DEPTH=4: latency 1 and 4.

Source files
------------

// File: rtl/masked_xor_pipe_pkg.sv
// masked_xor_pipe_pkg: mode encodings and share-slice helpers; no ports
package masked_xor_pipe_pkg;
  typedef enum logic [1:0] {
    MODE_PASS    = 2'b00,
    MODE_XOR     = 2'b01,
    MODE_REFRESH = 2'b10,
    MODE_BOTH    = 2'b11
  } mode_e;
  function automatic logic mode_xor(input logic [1:0] m);
    return m == MODE_XOR || m == MODE_BOTH;
  endfunction
  function automatic logic mode_refresh(input logic [1:0] m);
    return m == MODE_REFRESH || m == MODE_BOTH;
  endfunction
  function automatic int unsigned share_lsb(input int unsigned i, input int unsigned w);
    return i * w;
  endfunction
endpackage

// File: rtl/masked_xor_stage.sv
// masked_xor_stage: one pipeline register with valid bit; in: clk/rst/load/valid_in/data_in, out: valid_q/data_q
module masked_xor_stage #(
  parameter int W = 192
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         valid_in,
  input  logic [W-1:0] data_in,
  output logic         valid_q,
  output logic [W-1:0] data_q
);
  logic         valid_d;
  logic [W-1:0] data_d;
  always_comb begin
    valid_d = load ? valid_in : valid_q;
    data_d  = load && valid_in ? data_in : data_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/masked_xor_pipe.sv
// masked_xor_pipe: share-wise masked XOR/refresh pipeline; in: in_valid/mode/state_in/opnd_in/rand_in/out_ready, out: in_ready/out_valid/state_out/word_cnt
module masked_xor_pipe
  import masked_xor_pipe_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int SHARES = 3,
  parameter int DEPTH  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  mode,
  input  logic [WIDTH*SHARES-1:0]     state_in,
  input  logic [WIDTH*SHARES-1:0]     opnd_in,
  input  logic [WIDTH*(SHARES-1)-1:0] rand_in,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH*SHARES-1:0]     state_out,
  output logic [15:0]                 word_cnt
);
  localparam int N = WIDTH * SHARES;
  logic [WIDTH-1:0] m [SHARES];
  logic [N-1:0]     s0_d;
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] ld;
  logic [N-1:0]     d [DEPTH];
  logic             nxt;
  logic [15:0]      word_cnt_d, word_cnt_q;
  always_comb begin
    m = '{default: '0};
    for (int k = 0; k < SHARES - 1; k++) begin
      m[k]        = rand_in[share_lsb(k, WIDTH) +: WIDTH];
      m[SHARES-1] = m[SHARES-1] ^ m[k];
    end
  end
  always_comb begin
    s0_d = '0;
    for (int i = 0; i < SHARES; i++)
      s0_d[share_lsb(i, WIDTH) +: WIDTH] = state_in[share_lsb(i, WIDTH) +: WIDTH]
        ^ (mode_xor(mode) ? opnd_in[share_lsb(i, WIDTH) +: WIDTH] : '0)
        ^ (mode_refresh(mode) ? m[i] : '0);
  end
  always_comb begin
    ld  = '0;
    nxt = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      ld[k] = !v[k] || nxt;
      nxt   = ld[k];
    end
  end
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic         vi;
    logic [N-1:0] di;
    if (k == 0) begin : g_head
      assign vi = in_valid;
      assign di = s0_d;
    end else begin : g_body
      assign vi = v[k-1];
      assign di = d[k-1];
    end
    masked_xor_stage #(.W(N)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .load     (ld[k]),
      .valid_in (vi),
      .data_in  (di),
      .valid_q  (v[k]),
      .data_q   (d[k])
    );
  end
  always_comb word_cnt_d = word_cnt_q + 16'(in_valid && ld[0]);
  always_ff @(posedge clk) begin
    if (rst) word_cnt_q <= '0;
    else word_cnt_q <= word_cnt_d;
  end
  assign in_ready  = ld[0];
  assign out_valid = v[DEPTH-1];
  assign state_out = d[DEPTH-1];
  assign word_cnt  = word_cnt_q;
endmodule

// File: tb/tb_masked_xor_pipe.sv
// tb_masked_xor_pipe: scoreboard bench for masked_xor_pipe (DEPTH 2 main, DEPTH 1 and 4 latency)
module tb_masked_xor_pipe;
  localparam int W = 64, S = 3, N = W * S, R = W * (S - 1);
  logic clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [1:0] mode = 2'b00;
  logic [N-1:0] state_in = '0, opnd_in = '0;
  logic [R-1:0] rand_in = '0;
  logic in_ready, out_valid, in_ready1, out_valid1, in_ready4, out_valid4;
  logic [N-1:0] state_out, state_out1, state_out4;
  logic [15:0] word_cnt, word_cnt1, word_cnt4;
  always #5 clk = ~clk;
  masked_xor_pipe #(.WIDTH(W), .SHARES(S), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .state_in(state_in), .opnd_in(opnd_in), .rand_in(rand_in), .out_valid(out_valid),
    .out_ready(out_ready), .state_out(state_out), .word_cnt(word_cnt));
  masked_xor_pipe #(.WIDTH(W), .SHARES(S), .DEPTH(1)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .mode(mode),
    .state_in(state_in), .opnd_in(opnd_in), .rand_in(rand_in), .out_valid(out_valid1),
    .out_ready(out_ready), .state_out(state_out1), .word_cnt(word_cnt1));
  masked_xor_pipe #(.WIDTH(W), .SHARES(S), .DEPTH(4)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4), .mode(mode),
    .state_in(state_in), .opnd_in(opnd_in), .rand_in(rand_in), .out_valid(out_valid4),
    .out_ready(out_ready), .state_out(state_out4), .word_cnt(word_cnt4));
  int checks = 0, failures = 0, n_out = 0;
  logic [N-1:0] exp_q[$];
  logic [W-1:0] unsh_q[$];
  logic [N-1:0] last_out = '0, held = '0;
  bit stall = 0;
  function automatic logic [W-1:0] fold(input logic [N-1:0] x);
    logic [W-1:0] f;
    f = '0;
    for (int i = 0; i < S; i++) f ^= x[i*W +: W];
    return f;
  endfunction
  function automatic logic [N-1:0] rndn();
    logic [N-1:0] x;
    for (int i = 0; i < N / 32; i++) x[i*32 +: 32] = $urandom;
    return x;
  endfunction
  function automatic logic [N-1:0] model(input logic [1:0] md, input logic [N-1:0] s, input logic [N-1:0] o,
                                         input logic [R-1:0] r);
    logic [W-1:0] mk [S];
    logic [N-1:0] e;
    mk[S-1] = '0;
    for (int k = 0; k < S - 1; k++) begin
      mk[k] = r[k*W +: W];
      mk[S-1] ^= mk[k];
    end
    for (int i = 0; i < S; i++)
      e[i*W +: W] = s[i*W +: W] ^ (md[0] ? o[i*W +: W] : '0) ^ (md[1] ? mk[i] : '0);
    return e;
  endfunction
  task automatic chk(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) stall = 0;
    else begin
      if (stall) begin
        chk("hold_valid", N'(out_valid), N'(1));
        chk("hold_data", state_out, held);
      end
      if (out_valid && out_ready) begin
        n_out++;
        last_out = state_out;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out: got %h expected none", state_out);
        end else begin
          chk("data", state_out, exp_q.pop_front());
          chk("unshared", N'(fold(state_out)), N'(unsh_q.pop_front()));
        end
      end
      stall = out_valid && !out_ready;
      held  = state_out;
    end
  end
  task automatic send(input logic [1:0] md, input logic [N-1:0] s, input logic [N-1:0] o,
                      input logic [R-1:0] r, output bit ok);
    in_valid = 1; mode = md; state_in = s; opnd_in = o; rand_in = r; ok = 0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (in_ready && !rst) begin
        exp_q.push_back(model(md, s, o, r));
        unsh_q.push_back(fold(s) ^ (md[0] ? fold(o) : '0));
        ok = 1;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: got no accept expected accept within 20 cycles");
    end
  endtask
  task automatic send_rand(output bit ok);
    send(2'($urandom), rndn(), rndn(), R'(rndn()), ok);
  endtask
  task automatic wait_drain();
    for (int t = 0; t < 40 && exp_q.size() != 0; t++) begin
      @(posedge clk); #1;
    end
    chk("drain", N'(exp_q.size()), N'(0));
  endtask
  task automatic do_reset();
    rst = 1; in_valid = 0;
    @(posedge clk); #1;
    rst = 0;
    exp_q.delete();
    unsh_q.delete();
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bit ok;
    int acc, n0, lat1, lat2, lat4;
    logic [N-1:0] s, o, o1, o4;
    logic [W-1:0] eu;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    chk("rst_out_valid", N'(out_valid), N'(0));
    chk("rst_state_out", state_out, '0);
    chk("rst_word_cnt", N'(word_cnt), N'(0));
    chk("rst_in_ready", N'(in_ready), N'(1));
    // test 1: xor mode with latency on DEPTH 1, 2 and 4
    s = rndn(); o = rndn(); eu = fold(s) ^ fold(o);
    send(2'b01, s, o, R'(rndn()), ok);
    in_valid = 0;
    lat1 = 0; lat2 = 0; lat4 = 0; o1 = '0; o4 = '0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (out_valid1 && lat1 == 0) begin lat1 = n; o1 = state_out1; end
      if (out_valid && lat2 == 0) lat2 = n;
      if (out_valid4 && lat4 == 0) begin lat4 = n; o4 = state_out4; end
      @(posedge clk); #1;
    end
    chk("lat_d1", N'(lat1), N'(1));
    chk("lat_d2", N'(lat2), N'(2));
    chk("lat_d4", N'(lat4), N'(4));
    chk("unsh_d1", N'(fold(o1)), N'(eu));
    chk("unsh_d4", N'(fold(o4)), N'(eu));
    chk("data_d1", o1, s ^ o);
    wait_drain();
    // test 2: refresh keeps the unshared value
    send(2'b10, {64'd3, 64'd2, 64'd1}, rndn(), {64'hF0, 64'hFF}, ok);
    in_valid = 0;
    wait_drain();
    chk("refresh_vec", last_out, {64'h0C, 64'hF2, 64'hFE});
    // test 3: back-pressure
    n0 = n_out;
    out_ready = 0;
    send_rand(ok);
    send_rand(ok);
    in_valid = 1; state_in = rndn();
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      chk("bp_in_ready", N'(in_ready), N'(0));
      chk("bp_out_valid", N'(out_valid), N'(1));
      @(posedge clk); #1;
    end
    out_ready = 1;
    send_rand(ok);
    send_rand(ok);
    in_valid = 0;
    wait_drain();
    chk("bp_count", N'(n_out - n0), N'(4));
    // test 4: throughput
    do_reset();
    n0 = n_out; acc = 0;
    for (int t = 0; t < 100; t++) begin
      send_rand(ok);
      acc += int'(ok);
    end
    in_valid = 0;
    chk("tp_accepts", N'(acc), N'(100));
    chk("tp_outputs", N'(n_out - n0), N'(98));
    @(negedge clk);
    chk("tp_word_cnt", N'(word_cnt), N'(100));
    wait_drain();
    // test 5: reset with words in flight, accept during reset discarded
    do_reset();
    out_ready = 0;
    send_rand(ok);
    send_rand(ok);
    in_valid = 1; state_in = rndn(); rst = 1;
    @(posedge clk); #1;
    rst = 0; in_valid = 0;
    exp_q.delete();
    unsh_q.delete();
    chk("mr_out_valid", N'(out_valid), N'(0));
    chk("mr_state_out", state_out, '0);
    chk("mr_word_cnt", N'(word_cnt), N'(0));
    chk("mr_in_ready", N'(in_ready), N'(1));
    out_ready = 1;
    n0 = n_out;
    repeat (6) begin @(posedge clk); #1; end
    chk("mr_no_stale", N'(n_out - n0), N'(0));
    // test 6: counter wrap
    do_reset();
    for (int t = 0; t < 65535; t++) send_rand(ok);
    in_valid = 0;
    @(negedge clk);
    chk("wrap_pre", N'(word_cnt), N'(16'hFFFF));
    @(posedge clk); #1;
    send_rand(ok);
    in_valid = 0;
    @(negedge clk);
    chk("wrap_zero", N'(word_cnt), N'(0));
    @(posedge clk); #1;
    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
